chan_scan_mux: RTL and testbench

Parametrised, registered N-channel word selector with a manual-select mode and an auto-scan mode that steps through all channels on a programmable dwell period. It sits between the result/display sources and the output driver of the final-project datapath. It replaces hard-wired 10-way selection with a packed input bus and range checking. Auto-scan time-multiplexes channels onto one output, for example for display refresh.

---
 rtl/chan_scan_mux.sv | 135 +++++++++++++
 tb/tb_chan_scan_mux.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/chan_scan_mux.sv
// -----------------------------------------------------------------------------
// chan_scan_mux
//   Registered N-channel word selector. In manual mode the output follows a
//   select index. In auto-scan mode it steps through every channel, holding
//   each one for DWELL cycles. Typical use is time-multiplexing several result
//   words onto one display driver.
//
//   Parameters
//     WIDTH  : bits per channel word
//     NUM_CH : number of channels (>= 2)
//     SEL_W  : select width (2**SEL_W >= NUM_CH)
//     DWELL  : cycles each channel is held while scanning (>= 1)
//
//   Ports
//     clk      : system clock, rising edge
//     rst_n    : asynchronous active-low reset
//     in_bus   : packed channel words, channel k at [k*WIDTH +: WIDTH]
//     mode     : 0 = manual select, 1 = auto-scan
//     sel      : manual channel index (ignored while scanning)
//     hold     : scan only; freezes the dwell counter and current channel
//     out_data : registered selected word (zero for an out-of-range index)
//     out_ch   : registered index of the channel driving out_data
//     sel_err  : registered; manual sel is >= NUM_CH
//     ch_step  : one-cycle strobe in the first cycle out_ch shows a new
//                scan channel
// -----------------------------------------------------------------------------
module chan_scan_mux #(
  parameter int WIDTH  = 16,
  parameter int NUM_CH = 10,
  parameter int SEL_W  = 4,
  parameter int DWELL  = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_bus,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    hold,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    sel_err,
  output logic                    ch_step
);

  localparam int                DW_W       = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int                NUM_SLOT   = 2 ** SEL_W;
  localparam logic [SEL_W-1:0]  LAST_CH    = SEL_W'(NUM_CH - 1);
  localparam logic [DW_W-1:0]   LAST_DWELL = DW_W'(DWELL - 1);
  // One extra bit so NUM_CH == 2**SEL_W is still representable.
  localparam logic [SEL_W:0]    NUM_CH_X   = (SEL_W + 1)'(NUM_CH);

  // Every possible select value gets a slot; slots past the last channel are
  // tied to zero, which gives the out-of-range behaviour without a separate
  // compare in the data path.
  logic [WIDTH-1:0] slot_word [NUM_SLOT];

  generate
    for (genvar gi = 0; gi < NUM_SLOT; gi++) begin : g_slot
      if (gi < NUM_CH) begin : g_live
        assign slot_word[gi] = in_bus[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign slot_word[gi] = '0;
      end
    end
  endgenerate

  logic [SEL_W-1:0] scan_ch_reg,   scan_ch_next;
  logic [DW_W-1:0]  dwell_cnt_reg, dwell_cnt_next;
  logic             step_pend_reg, step_pend_next;
  logic [WIDTH-1:0] out_data_reg,  out_data_next;
  logic [SEL_W-1:0] out_ch_reg,    out_ch_next;
  logic             sel_err_reg,   sel_err_next;
  logic             ch_step_reg,   ch_step_next;
  logic [SEL_W-1:0] eff_ch;

  assign eff_ch = mode ? scan_ch_reg : sel;

  // Output stage: everything is registered, no input reaches an output
  // combinationally.
  always_comb begin
    out_ch_next   = eff_ch;
    out_data_next = slot_word[eff_ch];
    sel_err_next  = ~mode & ({1'b0, sel} >= NUM_CH_X);
    // Leaving scan mode drops a strobe that was still pending.
    ch_step_next  = mode & step_pend_reg;
  end

  // Scan position. Manual mode parks the scanner at channel 0 with a fresh
  // dwell count, so re-entering scan always starts a full period on channel 0.
  always_comb begin
    scan_ch_next   = scan_ch_reg;
    dwell_cnt_next = dwell_cnt_reg;
    step_pend_next = 1'b0;
    if (!mode) begin
      scan_ch_next   = '0;
      dwell_cnt_next = '0;
    end else if (!hold) begin
      if (dwell_cnt_reg == LAST_DWELL) begin
        dwell_cnt_next = '0;
        scan_ch_next   = (scan_ch_reg == LAST_CH) ? '0 : scan_ch_reg + SEL_W'(1);
        // Strobe lands one edge later, together with out_ch showing the
        // new channel.
        step_pend_next = 1'b1;
      end else begin
        dwell_cnt_next = dwell_cnt_reg + DW_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_ch_reg   <= '0;
      dwell_cnt_reg <= '0;
      step_pend_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ch_reg    <= '0;
      sel_err_reg   <= 1'b0;
      ch_step_reg   <= 1'b0;
    end else begin
      scan_ch_reg   <= scan_ch_next;
      dwell_cnt_reg <= dwell_cnt_next;
      step_pend_reg <= step_pend_next;
      out_data_reg  <= out_data_next;
      out_ch_reg    <= out_ch_next;
      sel_err_reg   <= sel_err_next;
      ch_step_reg   <= ch_step_next;
    end
  end

  assign out_data = out_data_reg;
  assign out_ch   = out_ch_reg;
  assign sel_err  = sel_err_reg;
  assign ch_step  = ch_step_reg;

endmodule

// File: tb/tb_chan_scan_mux.sv
// -----------------------------------------------------------------------------
// tb_chan_scan_mux
//   Directed bench for chan_scan_mux (WIDTH=16, NUM_CH=10, SEL_W=4, DWELL=4).
//   The driver applies inputs on the falling edge and queues the hand-derived
//   response expected after the next rising edge; an independent monitor pops
//   and compares one entry per rising edge. Reset behaviour is checked directly.
// -----------------------------------------------------------------------------
module tb_chan_scan_mux;

  localparam int WIDTH  = 16;
  localparam int NUM_CH = 10;
  localparam int SEL_W  = 4;
  localparam int DWELL  = 4;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic [NUM_CH*WIDTH-1:0] in_bus = '0;
  logic                    mode = 1'b0;
  logic [SEL_W-1:0]        sel = '0;
  logic                    hold = 1'b0;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    sel_err;
  logic                    ch_step;

  chan_scan_mux #(
    .WIDTH (WIDTH),
    .NUM_CH(NUM_CH),
    .SEL_W (SEL_W),
    .DWELL (DWELL)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_bus  (in_bus),
    .mode    (mode),
    .sel     (sel),
    .hold    (hold),
    .out_data(out_data),
    .out_ch  (out_ch),
    .sel_err (sel_err),
    .ch_step (ch_step)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  ch;
    logic        err;
    logic        step;
    string       name;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] w [NUM_CH];
  int          checks = 0;
  int          errors = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Apply one cycle of stimulus and queue the response it should produce.
  task automatic drive(input logic m, input logic [3:0] s, input logic h,
                       input logic [15:0] ed, input logic [3:0] ec,
                       input logic ee, input logic es, input string nm);
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < NUM_CH; k++) in_bus[k*WIDTH +: WIDTH] = w[k];
    mode = m;
    sel  = s;
    hold = h;
    e.data = ed; e.ch = ec; e.err = ee; e.step = es; e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: one comparison set per rising edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cmp({e.name, ".out_data"}, 32'(out_data), 32'(e.data));
        cmp({e.name, ".out_ch"},   32'(out_ch),   32'(e.ch));
        cmp({e.name, ".sel_err"},  32'(sel_err),  32'(e.err));
        cmp({e.name, ".ch_step"},  32'(ch_step),  32'(e.step));
        $display("txn %s: ch=%0d data=%04h err=%0b step=%0b", e.name, out_ch,
                 out_data, sel_err, ch_step);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  // Scan through channels first_ch..last_ch, DWELL cycles each; a strobe is
  // expected on the first cycle of each channel when step_first is set.
  task automatic scan_run(input int first_ch, input int last_ch, input int first_r,
                          input int last_r_of_last, input bit step_first, input string nm);
    for (int c = first_ch; c <= last_ch; c++) begin
      for (int r = (c == first_ch) ? first_r : 0;
           r <= ((c == last_ch) ? last_r_of_last : DWELL - 1); r++) begin
        drive(1'b1, 4'hF, 1'b0, 16'(16'hA000 + c), 4'(c), 1'b0,
              (r == 0) && (step_first || c != first_ch), nm);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NUM_CH; k++) w[k] = 16'(16'hA000 + k);
    for (int k = 0; k < NUM_CH; k++) in_bus[k*WIDTH +: WIDTH] = w[k];

    // Reset: all outputs 0.
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    cmp("rst.out_data", 32'(out_data), 32'h0);
    cmp("rst.out_ch",   32'(out_ch),   32'h0);
    cmp("rst.sel_err",  32'(sel_err),  32'h0);
    cmp("rst.ch_step",  32'(ch_step),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Manual select, including out of range.
    drive(1'b0, 4'd7, 1'b0, 16'hA007, 4'd7,  1'b0, 1'b0, "man_sel7");
    drive(1'b0, 4'hC, 1'b0, 16'h0000, 4'hC, 1'b1, 1'b0, "man_selC");
    drive(1'b0, 4'd9, 1'b0, 16'hA009, 4'd9,  1'b0, 1'b0, "man_sel9");
    drive(1'b0, 4'hA, 1'b0, 16'h0000, 4'hA, 1'b1, 1'b0, "man_selA");

    // Full rotation from idle: no strobe on entry to channel 0, strobe on wrap.
    scan_run(0, 9, 0, DWELL - 1, 1'b0, "scan");
    drive(1'b1, 4'hF, 1'b0, 16'hA000, 4'd0, 1'b0, 1'b1, "wrap");

    // Continue to channel 2, hold for 3 cycles during its second cycle.
    scan_run(0, 2, 1, 0, 1'b0, "pre_hold");
    for (int i = 0; i < 3; i++) begin
      w[2] = 16'(16'h2B00 + i);
      drive(1'b1, 4'hF, 1'b1, w[2], 4'd2, 1'b0, 1'b0, "hold");
    end
    for (int i = 0; i < 3; i++) begin
      w[2] = 16'(16'h2C00 + i);
      drive(1'b1, 4'hF, 1'b0, w[2], 4'd2, 1'b0, 1'b0, "post_hold");
    end
    w[2] = 16'hA002;
    scan_run(3, 5, 0, 1, 1'b1, "to_ch5");

    // Mode toggling.
    drive(1'b0, 4'd1, 1'b0, 16'hA001, 4'd1, 1'b0, 1'b0, "manual_back");
    scan_run(0, 6, 0, 1, 1'b0, "rescan");
    drain();

    // Asynchronous reset between edges while on channel 6.
    cmp("pre_rst.out_ch", 32'(out_ch), 32'd6);
    #1 rst_n = 1'b0;
    #1;
    cmp("arst.out_data", 32'(out_data), 32'h0);
    cmp("arst.out_ch",   32'(out_ch),   32'h0);
    cmp("arst.ch_step",  32'(ch_step),  32'h0);
    rst_n = 1'b1;
    scan_run(0, 1, 0, 0, 1'b0, "after_rst");
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
